mem_access_arbiter: RTL and testbench
=====================================

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 The module SHALL have the port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port Reset, input, 1 bit: synchronous, active-high reset sampled on rising Clk.
REQ-003 The module SHALL have the fetch-port signals IfReq in 1 (request), IfAddress in 9 (byte address), IfDataOut out 32 (fetched word) and IfDone out 1 (completion pulse).
REQ-004 The module SHALL have the data-port signals DReq in 1, DReadWrite in 1 (1=write, 0=read), DSize in 2, DSE in 1 (sign extend), DAddress in 9, DDataIn in 32, DDataOut out 32 and DDone out 1.
REQ-005 The module SHALL have the memory-side signals MemEnable out 1, MemReadWrite out 1, MemAddress out 9, MemByteOut out 8 (write byte) and MemByteIn in 8 (combinational read byte at MemAddress).
REQ-006 The module SHALL have the port Busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-007 The module SHALL implement the states IDLE, XFER and DONE.
REQ-008 In IDLE with any Req high at a rising edge, the module SHALL grant one port, latch its address, size, direction, SE and write data, clear the byte index, and go to XFER.
REQ-009 The module SHALL treat a fetch as a word read (size 2'b10, no sign extension).
REQ-010 When both Req are high, the module SHALL grant round-robin: the port not granted last wins; LastGrant updates at each grant.
REQ-011 The module SHALL set the byte count N as: DSize 00 gives 1, DSize 01 gives 2, DSize 10 or 11 gives 4.
REQ-012 In XFER, each cycle SHALL drive MemEnable=1, MemReadWrite=latched direction, and MemAddress=(base+index) mod 512, so 0x1FF wraps to 0x000.
REQ-013 Transfers SHALL be big-endian: index 0 carries the most significant byte of the N-byte quantity (for writes, DDataIn[8N-1:8N-8]).
REQ-014 On reads, the module SHALL shift MemByteIn into an assembly register at each XFER rising edge.
REQ-015 After the edge that completes byte N-1, the module SHALL go to DONE.
REQ-016 In DONE, the module SHALL pulse the granted port's Done for exactly one cycle, hold MemEnable=0, and go to IDLE next edge.
REQ-017 For a read, the module SHALL update the granted port's DataOut as the DONE cycle starts and hold it until that port's next read completes.
REQ-018 Read extension SHALL be: 1 byte gives {24{SE&b[7]}, b}; 2 bytes gives {16{SE&h[15]}, h}; 4 bytes gives no extension.
REQ-019 Latency SHALL be: Req sampled in IDLE at edge k, then XFER during cycles k+1..k+N, then Done high in cycle k+N+1, then IDLE at k+N+2.
REQ-020 The module SHALL ignore Req levels during XFER and DONE; a requester holds Req until Done and drops it in the Done cycle, and Req still high in IDLE is a new request.
REQ-021 The module SHALL ignore changes to address, data, size or direction inputs after the grant.
REQ-022 Outside XFER, the module SHALL drive MemEnable, MemReadWrite, MemAddress and MemByteOut to 0.
REQ-023 The module SHALL transfer misaligned addresses byte-by-byte with no error.

Reset
REQ-024 Reset SHALL force: state IDLE; IfDone, DDone, Busy, MemEnable and MemReadWrite at 0; MemAddress, MemByteOut, IfDataOut and DDataOut at 0; and LastGrant=fetch, so the data port wins the first tie.
REQ-025 Reset during XFER SHALL abort the transfer, with no further memory writes after the reset edge and no Done pulse; Reset has priority over every other event.

Verification
REQ-026 Data word write 0xDEADBEEF at 0x010 SHALL produce MemAddress 0x010..0x013 with bytes DE, AD, BE, EF over 4 cycles and DDone in the 5th cycle after the grant edge.
REQ-027 Data byte read of 0x80 SHALL return DDataOut 0xFFFFFF80 with DSE=1 and 0x00000080 with DSE=0; a halfword read of 0x8001 with DSE=1 SHALL return 0xFFFF8001.
REQ-028 IfReq and DReq high together after reset SHALL serve data first, then fetch; a second tie SHALL serve data again, alternating correctly.
REQ-029 Halfword write 0xABCD at 0x1FF SHALL write 0xAB to 0x1FF and then 0xCD to 0x000.
REQ-030 Reset asserted in the 2nd XFER cycle of a word write SHALL give MemEnable=0 and Busy=0 on the next cycle, no DDone, and a following fetch served normally.
REQ-031 Fetch at 0x020 with memory holding 12, 34, 56, 78 SHALL return IfDataOut 0x12345678 with IfDone high for one cycle and DDataOut unchanged.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Two-port memory access arbiter: a fetch port and a data port share one
// byte-wide memory. Multi-byte quantities are moved one byte per cycle,
// big-endian. Ties are broken round-robin.
module mem_access_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IfReq,
    input  logic [8:0]  IfAddress,
    output logic [31:0] IfDataOut,
    output logic        IfDone,
    input  logic        DReq,
    input  logic        DReadWrite,
    input  logic [1:0]  DSize,
    input  logic        DSE,
    input  logic [8:0]  DAddress,
    input  logic [31:0] DDataIn,
    output logic [31:0] DDataOut,
    output logic        DDone,
    output logic        MemEnable,
    output logic        MemReadWrite,
    output logic [8:0]  MemAddress,
    output logic [7:0]  MemByteOut,
    input  logic [7:0]  MemByteIn,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bytes moved for a given size code.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            2'b00:   byte_count = 3'd1;
            2'b01:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    // Move the N-byte quantity to the top of the word so bits [31:24]
    // always hold the next byte to send.
    function automatic logic [31:0] left_align(input logic [31:0] data, input logic [2:0] n);
        case (n)
            3'd1:    left_align = {data[7:0], 24'd0};
            3'd2:    left_align = {data[15:0], 16'd0};
            default: left_align = data;
        endcase
    endfunction

    // Zero or sign extend an assembled read of N bytes.
    function automatic logic [31:0] extend(input logic [31:0] word, input logic [2:0] n, input logic se);
        case (n)
            3'd1:    extend = {{24{se & word[7]}}, word[7:0]};
            3'd2:    extend = {{16{se & word[15]}}, word[15:0]};
            default: extend = word;
        endcase
    endfunction

    state_t      state_r;
    logic        grant_data_r;       // 1 = data port owns the current transfer
    logic        last_grant_data_r;  // 1 = data port won the previous grant
    logic        rw_r;
    logic        se_r;
    logic [2:0]  n_r;
    logic [2:0]  idx_r;
    logic [8:0]  base_r;
    logic [31:0] wdata_r;            // remaining write bytes, next one in [31:24]
    logic [23:0] asm_r;              // read bytes gathered so far

    logic        pick_data_s;
    logic        sel_rw_s;
    logic        sel_se_s;
    logic [2:0]  sel_n_s;
    logic [8:0]  sel_addr_s;
    logic [31:0] sel_aligned_s;
    logic [31:0] assembled_s;
    logic [31:0] read_result_s;
    logic [8:0]  next_addr_s;
    logic        last_byte_s;

    // Grant selection, request field muxing and per-byte datapath.
    always_comb begin
        pick_data_s   = DReq & (~IfReq | ~last_grant_data_r);
        sel_rw_s      = pick_data_s ? DReadWrite : 1'b0;
        sel_se_s      = pick_data_s ? DSE : 1'b0;
        sel_n_s       = pick_data_s ? byte_count(DSize) : 3'd4;
        sel_addr_s    = pick_data_s ? DAddress : IfAddress;
        sel_aligned_s = pick_data_s ? left_align(DDataIn, sel_n_s) : 32'd0;
        assembled_s   = {asm_r, MemByteIn};
        read_result_s = extend(assembled_s, n_r, se_r);
        next_addr_s   = base_r + {6'd0, idx_r} + 9'd1;
        last_byte_s   = (idx_r == (n_r - 3'd1));
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r           <= IDLE;
            grant_data_r      <= 1'b0;
            last_grant_data_r <= 1'b0;
            rw_r              <= 1'b0;
            se_r              <= 1'b0;
            n_r               <= 3'd0;
            idx_r             <= 3'd0;
            base_r            <= 9'd0;
            wdata_r           <= 32'd0;
            asm_r             <= 24'd0;
            IfDataOut         <= 32'd0;
            DDataOut          <= 32'd0;
            IfDone            <= 1'b0;
            DDone             <= 1'b0;
            Busy              <= 1'b0;
            MemEnable         <= 1'b0;
            MemReadWrite      <= 1'b0;
            MemAddress        <= 9'd0;
            MemByteOut        <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    IfDone <= 1'b0;
                    DDone  <= 1'b0;
                    if (IfReq || DReq) begin
                        state_r           <= XFER;
                        Busy              <= 1'b1;
                        grant_data_r      <= pick_data_s;
                        last_grant_data_r <= pick_data_s;
                        rw_r              <= sel_rw_s;
                        se_r              <= sel_se_s;
                        n_r               <= sel_n_s;
                        idx_r             <= 3'd0;
                        base_r            <= sel_addr_s;
                        wdata_r           <= {sel_aligned_s[23:0], 8'd0};
                        asm_r             <= 24'd0;
                        MemEnable         <= 1'b1;
                        MemReadWrite      <= sel_rw_s;
                        MemAddress        <= sel_addr_s;
                        MemByteOut        <= sel_rw_s ? sel_aligned_s[31:24] : 8'd0;
                    end else begin
                        Busy         <= 1'b0;
                        MemEnable    <= 1'b0;
                        MemReadWrite <= 1'b0;
                        MemAddress   <= 9'd0;
                        MemByteOut   <= 8'd0;
                    end
                end
                XFER: begin
                    asm_r <= assembled_s[23:0];
                    if (last_byte_s) begin
                        state_r      <= DONE;
                        MemEnable    <= 1'b0;
                        MemReadWrite <= 1'b0;
                        MemAddress   <= 9'd0;
                        MemByteOut   <= 8'd0;
                        if (grant_data_r) begin
                            DDone <= 1'b1;
                            if (!rw_r) begin
                                DDataOut <= read_result_s;
                            end
                        end else begin
                            IfDone <= 1'b1;
                            if (!rw_r) begin
                                IfDataOut <= read_result_s;
                            end
                        end
                    end else begin
                        idx_r      <= idx_r + 3'd1;
                        MemAddress <= next_addr_s;
                        MemByteOut <= rw_r ? wdata_r[31:24] : 8'd0;
                        wdata_r    <= {wdata_r[23:0], 8'd0};
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    IfDone       <= 1'b0;
                    DDone        <= 1'b0;
                    Busy         <= 1'b0;
                    MemEnable    <= 1'b0;
                    MemReadWrite <= 1'b0;
                    MemAddress   <= 9'd0;
                    MemByteOut   <= 8'd0;
                end
                default: begin
                    state_r      <= IDLE;
                    IfDone       <= 1'b0;
                    DDone        <= 1'b0;
                    Busy         <= 1'b0;
                    MemEnable    <= 1'b0;
                    MemReadWrite <= 1'b0;
                    MemAddress   <= 9'd0;
                    MemByteOut   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: a byte memory model, a queue of
// expected memory writes and a queue of expected completions.
module tb_mem_access_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IfReq;
    logic [8:0]  IfAddress;
    logic [31:0] IfDataOut;
    logic        IfDone;
    logic        DReq;
    logic        DReadWrite;
    logic [1:0]  DSize;
    logic        DSE;
    logic [8:0]  DAddress;
    logic [31:0] DDataIn;
    logic [31:0] DDataOut;
    logic        DDone;
    logic        MemEnable;
    logic        MemReadWrite;
    logic [8:0]  MemAddress;
    logic [7:0]  MemByteOut;
    logic [7:0]  MemByteIn;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] wr_q[$];    // {addr, byte}
    logic [33:0] done_q[$];  // {is_data_port, is_read, expected data}

    logic [7:0] mem [0:511];

    mem_access_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .IfReq(IfReq), .IfAddress(IfAddress), .IfDataOut(IfDataOut), .IfDone(IfDone),
        .DReq(DReq), .DReadWrite(DReadWrite), .DSize(DSize), .DSE(DSE),
        .DAddress(DAddress), .DDataIn(DDataIn), .DDataOut(DDataOut), .DDone(DDone),
        .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemAddress(MemAddress),
        .MemByteOut(MemByteOut), .MemByteIn(MemByteIn), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    assign MemByteIn = mem[MemAddress];

    // Memory model write port.
    always @(posedge Clk) begin
        if (MemEnable === 1'b1 && MemReadWrite === 1'b1) mem[MemAddress] <= MemByteOut;
    end

    // Scoreboard: compare memory writes and completions against the queues.
    always @(negedge Clk) begin
        logic [16:0] ew;
        logic [33:0] ed;
        logic [31:0] act;
        if (MemEnable === 1'b1 && MemReadWrite === 1'b1) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_write: got addr %h byte %h, expected no write", MemAddress, MemByteOut);
            end else begin
                ew = wr_q.pop_front();
                if ({MemAddress, MemByteOut} !== ew) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr %h byte %h, expected addr %h byte %h",
                             MemAddress, MemByteOut, ew[16:8], ew[7:0]);
                end
            end
        end
        if (DDone === 1'b1 || IfDone === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done: got DDone %b IfDone %b, expected no completion", DDone, IfDone);
            end else begin
                ed  = done_q.pop_front();
                act = ed[33] ? DDataOut : IfDataOut;
                if ({DDone, IfDone} !== (ed[33] ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL done_port: got DDone %b IfDone %b, expected data_port=%b", DDone, IfDone, ed[33]);
                end else if (ed[32] && act !== ed[31:0]) begin
                    n_fail++;
                    $display("FAIL read_data: got %h, expected %h (data_port=%b)", act, ed[31:0], ed[33]);
                end
            end
        end
    end

    // Present a data-port request at the next falling edge.
    task automatic issue_d(input logic rw, input logic [1:0] size, input logic se,
                           input logic [8:0] addr, input logic [31:0] wdata);
        @(negedge Clk);
        DReq = 1'b1; DReadWrite = rw; DSize = size; DSE = se; DAddress = addr; DDataIn = wdata;
    endtask

    // Run until every raised request has seen its Done, dropping each in its Done cycle.
    task automatic service(input int budget);
        int c = 0;
        while ((IfReq || DReq) && c < budget) begin
            @(negedge Clk);
            c++;
            if (DDone === 1'b1) DReq = 1'b0;
            if (IfDone === 1'b1) IfReq = 1'b0;
        end
        n_checks++;
        if (IfReq || DReq) begin
            n_fail++;
            $display("FAIL service_timeout: requests IfReq %b DReq %b still pending after %0d cycles, expected 0 0",
                     IfReq, DReq, budget);
            IfReq = 1'b0; DReq = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; IfReq = 1'b0; DReq = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; IfReq = 1'b0; DReq = 1'b0; IfAddress = 9'd0;
        DReadWrite = 1'b0; DSize = 2'b00; DSE = 1'b0; DAddress = 9'd0; DDataIn = 32'd0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({Busy, IfDone, DDone, MemEnable, MemReadWrite} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got Busy/IfDone/DDone/MemEn/MemRW %b, expected 00000",
                     {Busy, IfDone, DDone, MemEnable, MemReadWrite});
        end
        n_checks++;
        if ({MemAddress, MemByteOut} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr %h byte %h, expected 000 00", MemAddress, MemByteOut);
        end
        n_checks++;
        if ({IfDataOut, DDataOut} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got IfDataOut %h DDataOut %h, expected 0 0", IfDataOut, DDataOut);
        end
        Reset = 1'b0;
    endtask

    task automatic test_word_write();
        int done_cyc = 0;
        issue_d(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
        wr_q.push_back({9'h010, 8'hDE}); wr_q.push_back({9'h011, 8'hAD});
        wr_q.push_back({9'h012, 8'hBE}); wr_q.push_back({9'h013, 8'hEF});
        done_q.push_back({1'b1, 1'b0, 32'd0});
        @(negedge Clk);
        n_checks++;
        if ({Busy, MemEnable, MemReadWrite, MemAddress} !== {3'b111, 9'h010}) begin
            n_fail++;
            $display("FAIL grant_cycle: got Busy %b MemEn %b MemRW %b addr %h, expected 1 1 1 010",
                     Busy, MemEnable, MemReadWrite, MemAddress);
        end
        // inputs change after the grant and must not matter
        DAddress = 9'h155; DDataIn = 32'h0; DSize = 2'b00; DReadWrite = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge Clk);
            if (DDone === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        DReq = 1'b0;
        n_checks++;
        if (done_cyc != 5) begin
            n_fail++;
            $display("FAIL write_latency: DDone in cycle %0d after grant, expected 5", done_cyc);
        end
        @(negedge Clk);
        n_checks++;
        if ({DDone, Busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL after_done: got DDone %b Busy %b, expected 0 0", DDone, Busy);
        end
    endtask

    task automatic test_byte_reads();
        mem[9'h050] = 8'h80; mem[9'h060] = 8'h80; mem[9'h061] = 8'h01;
        issue_d(1'b0, 2'b00, 1'b1, 9'h050, 32'd0);
        done_q.push_back({1'b1, 1'b1, 32'hFFFFFF80});
        service(20);
        issue_d(1'b0, 2'b00, 1'b0, 9'h050, 32'd0);
        done_q.push_back({1'b1, 1'b1, 32'h00000080});
        service(20);
        issue_d(1'b0, 2'b01, 1'b1, 9'h060, 32'd0);
        done_q.push_back({1'b1, 1'b1, 32'hFFFF8001});
        service(20);
    endtask

    task automatic test_halfword_wrap();
        issue_d(1'b1, 2'b01, 1'b0, 9'h1FF, 32'h0000ABCD);
        wr_q.push_back({9'h1FF, 8'hAB}); wr_q.push_back({9'h000, 8'hCD});
        done_q.push_back({1'b1, 1'b0, 32'd0});
        service(20);
        n_checks++;
        if ({mem[9'h1FF], mem[9'h000]} !== 16'hABCD) begin
            n_fail++;
            $display("FAIL wrap_mem: got mem[1FF] %h mem[000] %h, expected AB CD", mem[9'h1FF], mem[9'h000]);
        end
    endtask

    task automatic test_fetch();
        int seen = 0;
        mem[9'h020] = 8'h12; mem[9'h021] = 8'h34; mem[9'h022] = 8'h56; mem[9'h023] = 8'h78;
        @(negedge Clk);
        IfReq = 1'b1; IfAddress = 9'h020;
        done_q.push_back({1'b0, 1'b1, 32'h12345678});
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (IfDone === 1'b1) begin
                seen = 1;
                break;
            end
        end
        IfReq = 1'b0;
        n_checks++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL fetch_done: IfDone seen %0d, expected 1", seen);
        end
        @(negedge Clk);
        n_checks++;
        if (IfDone !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pulse: IfDone %b one cycle after pulse, expected 0", IfDone);
        end
        n_checks++;
        if (DDataOut !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL fetch_ddata: DDataOut %h, expected FFFF8001", DDataOut);
        end
    endtask

    task automatic test_reset_abort();
        mem[9'h102] = 8'h5A; mem[9'h103] = 8'h5A;
        issue_d(1'b1, 2'b10, 1'b0, 9'h100, 32'h11223344);
        wr_q.push_back({9'h100, 8'h11}); wr_q.push_back({9'h101, 8'h22});
        @(negedge Clk);   // first XFER cycle
        @(negedge Clk);   // second XFER cycle
        Reset = 1'b1; DReq = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({MemEnable, Busy, DDone} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_state: got MemEn %b Busy %b DDone %b, expected 0 0 0", MemEnable, Busy, DDone);
        end
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        n_checks++;
        if ({mem[9'h102], mem[9'h103]} !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL abort_mem: got mem[102] %h mem[103] %h, expected 5A 5A", mem[9'h102], mem[9'h103]);
        end
        @(negedge Clk);
        IfReq = 1'b1; IfAddress = 9'h020;
        done_q.push_back({1'b0, 1'b1, 32'h12345678});
        service(20);
    endtask

    task automatic test_round_robin();
        do_reset();
        mem[9'h040] = 8'hA1; mem[9'h041] = 8'hB2; mem[9'h042] = 8'hC3; mem[9'h043] = 8'hD4;
        for (int t = 0; t < 2; t++) begin
            issue_d(1'b0, 2'b10, 1'b0, 9'h040, 32'd0);
            IfReq = 1'b1; IfAddress = 9'h020;
            done_q.push_back({1'b1, 1'b1, 32'hA1B2C3D4});
            done_q.push_back({1'b0, 1'b1, 32'h12345678});
            service(40);
        end
        issue_d(1'b1, 2'b00, 1'b0, 9'h070, 32'h000000A5);
        wr_q.push_back({9'h070, 8'hA5});
        done_q.push_back({1'b1, 1'b0, 32'd0});
        service(20);
        issue_d(1'b0, 2'b10, 1'b0, 9'h040, 32'd0);
        IfReq = 1'b1; IfAddress = 9'h020;
        done_q.push_back({1'b0, 1'b1, 32'h12345678});
        done_q.push_back({1'b1, 1'b1, 32'hA1B2C3D4});
        service(40);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        test_reset();
        test_word_write();
        test_byte_reads();
        test_halfword_wrap();
        test_fetch();
        test_reset_abort();
        test_round_robin();
        repeat (3) @(negedge Clk);
        n_checks++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: %0d writes and %0d completions outstanding, expected 0 0",
                     wr_q.size(), done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
